// File: rtl/riscv_id_stage_pkg.sv
// Shared RV32I decode types: instruction fields, control bus, ID/EX payload and immediate helpers.
package riscv_id_stage_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned NB_REG_ADDR = 5;
  localparam int unsigned NB_OPCODE   = 7;
  localparam int unsigned NB_FUNCT3   = 3;

  localparam logic [NB_OPCODE-1:0] OP_R_R    = 7'b0110011;
  localparam logic [NB_OPCODE-1:0] OP_IMM    = 7'b0010011;
  localparam logic [NB_OPCODE-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [NB_OPCODE-1:0] OP_STORE  = 7'b0100011;
  localparam logic [NB_OPCODE-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [NB_OPCODE-1:0] OP_LUI    = 7'b0110111;
  localparam logic [NB_OPCODE-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [NB_OPCODE-1:0] OP_JAL    = 7'b1101111;
  localparam logic [NB_OPCODE-1:0] OP_JALR   = 7'b1100111;

  localparam logic [NB_FUNCT3-1:0] F3_SRL_SRA = 3'b101;
  localparam logic [NB_FUNCT3-1:0] ALU_ADD    = 3'b000;

  typedef struct packed {
    logic [6:0]             funct7;
    logic [NB_REG_ADDR-1:0] rs2;
    logic [NB_REG_ADDR-1:0] rs1;
    logic [NB_FUNCT3-1:0]   funct3;
    logic [NB_REG_ADDR-1:0] rd;
    logic [NB_OPCODE-1:0]   opcode;
  } instruction_t;

  typedef struct packed {
    logic                   alu_src1;
    logic                   alu_src2;
    logic [NB_FUNCT3-1:0]   alu_op;
    logic                   arith_logic;
    logic                   dmem_rd;
    logic                   dmem_wr;
    logic [NB_FUNCT3-1:0]   ld_st_funct3;
    logic                   rf_wr;
    logic                   wb_to_rf;
    logic [NB_REG_ADDR-1:0] rd;
  } control_bus_t;

  typedef struct packed {
    logic                   valid;
    control_bus_t           ctrl;
    logic [XLEN-1:0]        pc;
    logic [XLEN-1:0]        rs1_data;
    logic [XLEN-1:0]        rs2_data;
    logic [XLEN-1:0]        imm;
    logic [NB_REG_ADDR-1:0] rs1;
    logic [NB_REG_ADDR-1:0] rs2;
    logic                   branch;
    logic                   jal;
    logic                   jalr;
    logic                   illegal;
  } id_ex_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_sel_t;

  // Immediate reassembly; every format sign-extends from instruction bit 31.
  function automatic logic [XLEN-1:0] imm_extract(input instruction_t ins, input imm_sel_t sel);
    logic [XLEN-1:0] w;
    logic [XLEN-1:0] imm;
    w = ins;
    case (sel)
      IMM_I:   imm = {{20{w[31]}}, w[31:20]};
      IMM_S:   imm = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm = {w[31:12], 12'b0};
      IMM_J:   imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv_id_stage_regfile.sv
// 2-read / 1-write register file; x0 reads zero and same-cycle writes bypass to the readers.
module riscv_regfile
  import riscv_id_stage_pkg::*;
#(
  parameter int unsigned NB_WORD     = 32,
  parameter int unsigned N_REGISTERS = 32,
  localparam int unsigned NB_ADDR    = $clog2(N_REGISTERS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NB_ADDR-1:0] rs1,
  input  logic [NB_ADDR-1:0] rs2,
  output logic [NB_WORD-1:0] rs1_data,
  output logic [NB_WORD-1:0] rs2_data,
  input  logic               wr_en,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_WORD-1:0] wr_data
);

  logic [NB_WORD-1:0] regs [N_REGISTERS];
  logic               wr_act;

  assign wr_act = wr_en && (wr_addr != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_REGISTERS); i++) regs[i] <= '0;
    end else if (wr_act) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1 == '0)                  ? '0      :
                    (wr_act && (wr_addr == rs1)) ? wr_data : regs[rs1];
  assign rs2_data = (rs2 == '0)                  ? '0      :
                    (wr_act && (wr_addr == rs2)) ? wr_data : regs[rs2];

endmodule

// File: rtl/riscv_id_stage.sv
// RV32I decode stage: register file, instruction decode, load-use stall and the ID/EX register.
module riscv_id_stage
  import riscv_id_stage_pkg::*;
#(
  parameter int unsigned NB_WORD     = 32,
  parameter int unsigned N_REGISTERS = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [XLEN-1:0]        i_instruction,
  input  logic [NB_WORD-1:0]     i_pc,
  input  logic                   i_flush,
  input  logic                   i_wb_rf_wr,
  input  logic [NB_REG_ADDR-1:0] i_wb_rd,
  input  logic [NB_WORD-1:0]     i_wb_data,
  output logic                   o_stall,
  output logic                   o_valid,
  output control_bus_t           o_ctrl,
  output logic [NB_WORD-1:0]     o_pc,
  output logic [NB_WORD-1:0]     o_rs1_data,
  output logic [NB_WORD-1:0]     o_rs2_data,
  output logic [NB_WORD-1:0]     o_imm,
  output logic [NB_REG_ADDR-1:0] o_rs1,
  output logic [NB_REG_ADDR-1:0] o_rs2,
  output logic                   o_branch,
  output logic                   o_jal,
  output logic                   o_jalr,
  output logic                   o_illegal
);

  instruction_t       instr;
  logic [NB_WORD-1:0] rf_rs1_data;
  logic [NB_WORD-1:0] rf_rs2_data;
  id_ex_t             dec;
  id_ex_t             id_ex;
  logic               load_pending;

  assign instr = i_instruction;

  riscv_regfile #(
    .NB_WORD     (NB_WORD),
    .N_REGISTERS (N_REGISTERS)
  ) u_regfile (
    .clock    (i_clock),
    .reset    (i_reset),
    .rs1      (instr.rs1),
    .rs2      (instr.rs2),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .wr_en    (i_wb_rf_wr),
    .wr_addr  (i_wb_rd),
    .wr_data  (i_wb_data)
  );

  // Unused source indices and operands are zeroed so forwarding and the hazard check ignore them.
  function automatic id_ex_t decode(input instruction_t ins, input logic [XLEN-1:0] pc,
                                    input logic [XLEN-1:0] rs1_data,
                                    input logic [XLEN-1:0] rs2_data);
    id_ex_t       r;
    control_bus_t c;
    imm_sel_t     sel;
    logic         use1;
    logic         use2;
    logic         wr;
    r    = '0;
    c    = '0;
    sel  = IMM_NONE;
    use1 = 1'b0;
    use2 = 1'b0;
    wr   = 1'b0;
    case (ins.opcode)
      OP_R_R: begin
        use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
        c.alu_op      = ins.funct3;
        c.arith_logic = ins.funct7[5];
      end
      OP_IMM: begin
        use1 = 1'b1; wr = 1'b1; sel = IMM_I;
        c.alu_src2    = 1'b1;
        c.alu_op      = ins.funct3;
        c.arith_logic = (ins.funct3 == F3_SRL_SRA) && ins.funct7[5];
      end
      OP_LOAD: begin
        use1 = 1'b1; wr = 1'b1; sel = IMM_I;
        c.alu_src2     = 1'b1;
        c.alu_op       = ALU_ADD;
        c.dmem_rd      = 1'b1;
        c.ld_st_funct3 = ins.funct3;
        c.wb_to_rf     = 1'b1;
      end
      OP_STORE: begin
        use1 = 1'b1; use2 = 1'b1; sel = IMM_S;
        c.alu_src2     = 1'b1;
        c.alu_op       = ALU_ADD;
        c.dmem_wr      = 1'b1;
        c.ld_st_funct3 = ins.funct3;
      end
      OP_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; sel = IMM_B;
        c.ld_st_funct3 = ins.funct3;
        r.branch       = 1'b1;
      end
      OP_LUI: begin
        wr = 1'b1; sel = IMM_U;
        c.alu_src2 = 1'b1;
        c.alu_op   = ALU_ADD;
      end
      OP_AUIPC: begin
        wr = 1'b1; sel = IMM_U;
        c.alu_src1 = 1'b1;
        c.alu_src2 = 1'b1;
        c.alu_op   = ALU_ADD;
      end
      OP_JAL: begin
        wr = 1'b1; sel = IMM_J;
        c.alu_src1 = 1'b1;
        c.alu_src2 = 1'b1;
        r.jal      = 1'b1;
      end
      OP_JALR: begin
        use1 = 1'b1; wr = 1'b1; sel = IMM_I;
        c.alu_src2 = 1'b1;
        r.jalr     = 1'b1;
      end
      default: r.illegal = 1'b1;
    endcase
    if (wr && (ins.rd != '0)) begin
      c.rf_wr = 1'b1;
      c.rd    = ins.rd;
    end
    r.valid    = 1'b1;
    r.ctrl     = c;
    r.pc       = pc;
    r.imm      = imm_extract(ins, sel);
    r.rs1      = use1 ? ins.rs1 : '0;
    r.rs2      = use2 ? ins.rs2 : '0;
    r.rs1_data = use1 ? rs1_data : '0;
    r.rs2_data = use2 ? rs2_data : '0;
    return r;
  endfunction

  assign dec = decode(instr, i_pc, rf_rs1_data, rf_rs2_data);

  // A load in EX whose destination feeds a used source of the instruction in ID.
  assign load_pending = id_ex.valid && id_ex.ctrl.dmem_rd && (id_ex.ctrl.rd != '0);
  assign o_stall      = i_valid && !i_flush && load_pending &&
                        ((dec.rs1 == id_ex.ctrl.rd) || (dec.rs2 == id_ex.ctrl.rd));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      id_ex <= '0;
    end else if (i_flush || o_stall || !i_valid) begin
      id_ex <= '0;
    end else begin
      id_ex <= dec;
    end
  end

  assign o_valid    = id_ex.valid;
  assign o_ctrl     = id_ex.ctrl;
  assign o_pc       = id_ex.pc;
  assign o_rs1_data = id_ex.rs1_data;
  assign o_rs2_data = id_ex.rs2_data;
  assign o_imm      = id_ex.imm;
  assign o_rs1      = id_ex.rs1;
  assign o_rs2      = id_ex.rs2;
  assign o_branch   = id_ex.branch;
  assign o_jal      = id_ex.jal;
  assign o_jalr     = id_ex.jalr;
  assign o_illegal  = id_ex.illegal;

endmodule

// File: tb/tb_riscv_id_stage.sv
// Self-checking bench for riscv_id_stage: directed pinning cases, then randomized traffic vs a reference model.
`timescale 1ns/1ps
module tb_riscv_id_stage;
  import riscv_id_stage_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_valid = 1'b0;
  logic [31:0]  i_instruction = '0;
  logic [31:0]  i_pc = '0;
  logic         i_flush = 1'b0;
  logic         i_wb_rf_wr = 1'b0;
  logic [4:0]   i_wb_rd = '0;
  logic [31:0]  i_wb_data = '0;
  logic         o_stall, o_valid, o_branch, o_jal, o_jalr, o_illegal;
  control_bus_t o_ctrl;
  logic [31:0]  o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]   o_rs1, o_rs2;

  always #5 clk = ~clk;

  riscv_id_stage dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .i_instruction(i_instruction),
    .i_pc(i_pc), .i_flush(i_flush), .i_wb_rf_wr(i_wb_rf_wr), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .o_stall(o_stall), .o_valid(o_valid), .o_ctrl(o_ctrl),
    .o_pc(o_pc), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_branch(o_branch), .o_jal(o_jal), .o_jalr(o_jalr),
    .o_illegal(o_illegal)
  );

  int          checks = 0;
  int          errors = 0;
  id_ex_t      exp_q;
  logic        exp_stall = 1'b0;
  logic        seen_stall;
  logic [31:0] mregs [32];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic id_ex_t actual();
    id_ex_t a;
    a.valid = o_valid;     a.ctrl = o_ctrl;         a.pc = o_pc;
    a.rs1_data = o_rs1_data; a.rs2_data = o_rs2_data; a.imm = o_imm;
    a.rs1 = o_rs1;         a.rs2 = o_rs2;           a.branch = o_branch;
    a.jal = o_jal;         a.jalr = o_jalr;         a.illegal = o_illegal;
    return a;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (i_wb_rf_wr && i_wb_rd == idx) return i_wb_data;
    return mregs[idx];
  endfunction

  // Reference decode written from the opcode table, immediates computed arithmetically.
  function automatic id_ex_t m_decode(input logic [31:0] ins, input logic [31:0] pc);
    id_ex_t r;
    logic [6:0] op;
    logic [2:0] f3;
    bit u1, u2, wr;
    int imm, sx;
    r = '0; u1 = 0; u2 = 0; wr = 0; imm = 0;
    op = ins[6:0]; f3 = ins[14:12]; sx = int'(ins);
    case (op)
      7'b0110011: begin u1 = 1; u2 = 1; wr = 1; r.ctrl.alu_op = f3; r.ctrl.arith_logic = ins[30]; end
      7'b0010011: begin
        u1 = 1; wr = 1; imm = sx >>> 20; r.ctrl.alu_src2 = 1; r.ctrl.alu_op = f3;
        r.ctrl.arith_logic = (f3 == 3'd5) ? ins[30] : 1'b0;
      end
      7'b0000011: begin
        u1 = 1; wr = 1; imm = sx >>> 20; r.ctrl.alu_src2 = 1; r.ctrl.dmem_rd = 1;
        r.ctrl.ld_st_funct3 = f3; r.ctrl.wb_to_rf = 1;
      end
      7'b0100011: begin
        u1 = 1; u2 = 1; imm = (sx >>> 25) * 32 + int'(ins[11:7]);
        r.ctrl.alu_src2 = 1; r.ctrl.dmem_wr = 1; r.ctrl.ld_st_funct3 = f3;
      end
      7'b1100011: begin
        u1 = 1; u2 = 1; r.branch = 1; r.ctrl.ld_st_funct3 = f3;
        imm = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      end
      7'b0110111: begin wr = 1; imm = int'(ins & 32'hFFFFF000); r.ctrl.alu_src2 = 1; end
      7'b0010111: begin wr = 1; imm = int'(ins & 32'hFFFFF000); r.ctrl.alu_src1 = 1; r.ctrl.alu_src2 = 1; end
      7'b1101111: begin
        wr = 1; r.jal = 1; r.ctrl.alu_src1 = 1; r.ctrl.alu_src2 = 1;
        imm = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      end
      7'b1100111: begin u1 = 1; wr = 1; r.jalr = 1; imm = sx >>> 20; r.ctrl.alu_src2 = 1; end
      default: r.illegal = 1;
    endcase
    if (wr && ins[11:7] != 5'd0) begin
      r.ctrl.rf_wr = 1;
      r.ctrl.rd = ins[11:7];
    end
    r.valid = 1; r.pc = pc; r.imm = 32'(imm);
    r.rs1 = u1 ? ins[19:15] : 5'd0;
    r.rs2 = u2 ? ins[24:20] : 5'd0;
    r.rs1_data = u1 ? mread(ins[19:15]) : 32'd0;
    r.rs2_data = u2 ? mread(ins[24:20]) : 32'd0;
    return r;
  endfunction

  function automatic logic m_stall();
    id_ex_t d;
    if (!(i_valid && !i_flush && exp_q.valid && exp_q.ctrl.dmem_rd && exp_q.ctrl.rd != 5'd0)) return 1'b0;
    d = m_decode(i_instruction, i_pc);
    return (d.rs1 == exp_q.ctrl.rd) || (d.rs2 == exp_q.ctrl.rd);
  endfunction

  // One clock: stall checked mid-cycle, ID/EX compared on the following falling edge.
  task automatic cycle();
    id_ex_t nxt;
    #1;
    exp_stall  = m_stall();
    seen_stall = o_stall;
    chk("stall", 256'(o_stall), 256'(exp_stall));
    nxt = (i_flush || exp_stall || !i_valid) ? id_ex_t'('0) : m_decode(i_instruction, i_pc);
    @(posedge clk);
    if (i_wb_rf_wr && i_wb_rd != 5'd0) mregs[i_wb_rd] = i_wb_data;
    exp_q = nxt;
    @(negedge clk);
    chk("idex", 256'(actual()), 256'(exp_q));
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    i_valid = v; i_instruction = ins; i_pc = pc; i_flush = fl;
    i_wb_rf_wr = ww; i_wb_rd = wr; i_wb_data = wd;
    cycle();
  endtask

  logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  logic [31:0] rins, rpc;
  logic        rv;

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    exp_q = '0;
    @(negedge clk);
    chk("reset_idex", 256'(actual()), 256'(0));
    chk("reset_stall", 256'(o_stall), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    drive(1, 32'hFFD00293, 32'h100, 0, 0, 0, 0);
    chk("addi_imm", 256'(o_imm), 256'(32'hFFFFFFFD));
    chk("addi_src2", 256'(o_ctrl.alu_src2), 256'(1));
    chk("addi_op", 256'(o_ctrl.alu_op), 256'(0));
    chk("addi_rd", 256'(o_ctrl.rd), 256'(5));
    chk("addi_wr", 256'(o_ctrl.rf_wr), 256'(1));
    chk("addi_valid", 256'(o_valid), 256'(1));

    drive(1, 32'h00018233, 32'h104, 0, 1, 5'd3, 32'h1234);
    chk("bypass_rs1", 256'(o_rs1_data), 256'(32'h1234));
    drive(1, 32'h00000233, 32'h108, 0, 1, 5'd0, 32'hFF);
    chk("x0_same_cycle", 256'(o_rs1_data), 256'(0));
    drive(1, 32'h00000233, 32'h10C, 0, 0, 0, 0);
    chk("x0_later", 256'(o_rs1_data), 256'(0));

    drive(1, 32'h0000A303, 32'h110, 0, 0, 0, 0);
    drive(1, 32'h002303B3, 32'h114, 0, 0, 0, 0);
    chk("lu_stall", 256'(seen_stall), 256'(1));
    chk("lu_bubble", 256'(o_valid), 256'(0));
    drive(1, 32'h002303B3, 32'h114, 0, 0, 0, 0);
    chk("lu_restall", 256'(seen_stall), 256'(0));
    chk("lu_issue_rs1", 256'(o_rs1), 256'(6));
    chk("lu_issue_valid", 256'(o_valid), 256'(1));

    drive(1, 32'h0000A303, 32'h118, 0, 0, 0, 0);
    drive(1, 32'h002103B3, 32'h11C, 0, 0, 0, 0);
    chk("nodep_stall", 256'(seen_stall), 256'(0));

    drive(1, 32'h0000A303, 32'h120, 0, 0, 0, 0);
    drive(1, 32'h002303B3, 32'h124, 1, 0, 0, 0);
    chk("flush_stall", 256'(seen_stall), 256'(0));
    chk("flush_bubble", 256'(o_valid), 256'(0));

    drive(1, 32'hFE000CE3, 32'h128, 0, 1, 5'd27, 32'hDEAD);
    chk("beq_imm", 256'(o_imm), 256'(32'hFFFFFFF8));
    chk("beq_branch", 256'(o_branch), 256'(1));
    drive(1, 32'h001000EF, 32'h12C, 0, 1, 5'd5, 32'h55);
    chk("jal_imm", 256'(o_imm), 256'(32'h00000800));
    chk("jal_flag", 256'(o_jal), 256'(1));
    drive(1, 32'hABCDE137, 32'h130, 0, 0, 0, 0);
    chk("lui_imm", 256'(o_imm), 256'(32'hABCDE000));
    chk("lui_rs1", 256'(o_rs1_data), 256'(0));
    drive(1, 32'h0000007F, 32'h134, 0, 0, 0, 0);
    chk("ill_flag", 256'(o_illegal), 256'(1));
    chk("ill_ctrl", 256'(o_ctrl), 256'(0));
    chk("ill_valid", 256'(o_valid), 256'(1));

    // Reset asserted while a load-use stall is being raised.
    drive(1, 32'h0000A303, 32'h138, 0, 0, 0, 0);
    i_instruction = 32'h002303B3; i_pc = 32'h13C;
    #1;
    chk("pre_reset_stall", 256'(o_stall), 256'(1));
    #1 rst = 1'b1;
    #1;
    chk("reset_async_idex", 256'(actual()), 256'(0));
    chk("reset_async_stall", 256'(o_stall), 256'(0));
    exp_q = '0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h00328233, 32'h140, 0, 0, 0, 0);
    chk("post_reset_rs1", 256'(o_rs1_data), 256'(0));
    chk("post_reset_rs2", 256'(o_rs2_data), 256'(0));

    rpc = 32'h1000; rins = '0; rv = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!exp_stall) begin
        rins = $urandom;
        if ($urandom_range(0, 9) == 9) rins[6:0] = $urandom_range(0, 1) ? 7'h7F : 7'h0F;
        else rins[6:0] = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 2) == 0) rins[6:0] = 7'b0000011;
        rins[11:7]  = 5'($urandom_range(0, 7));
        rins[19:15] = 5'($urandom_range(0, 7));
        rins[24:20] = 5'($urandom_range(0, 7));
        rpc = rpc + 32'd4;
        rv  = ($urandom_range(0, 7) != 0);
      end
      drive(rv, rins, rpc, $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_id_stage.md
# riscv_id_stage

Instruction-decode stage of the RV32I pipeline. It sits between the IF/ID register and the EX stage and contains the 32×32 register file with its writeback port. It decodes each instruction into a `control_bus_t` plus operands and an immediate, and registers them into the ID/EX pipeline register. It also detects load-use hazards and raises a stall toward fetch.

## Interface
Parameters:
- `NB_WORD`, 32, datapath width.
- `N_REGISTERS`, 32, register file depth; x0 is hardwired to zero.

Ports:
- `i_clock`  in  1  single clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  the IF/ID register holds a real instruction.
- `i_instruction`  in  32  instruction (`instruction_t`).
- `i_pc`  in  32  PC of `i_instruction`.
- `i_flush`  in  1  EX redirect (taken branch/jump); kills the instruction currently in ID.
- `i_wb_rf_wr`  in  1  writeback enable.
- `i_wb_rd`  in  5  writeback destination.
- `i_wb_data`  in  32  writeback value.
- `o_stall`  out  1  combinational; fetch must hold the PC and IF/ID.
- `o_valid`  out  1  ID/EX holds a real instruction.
- `o_ctrl`  out  `control_bus_t`  registered control bus.
- `o_pc`  out  32  registered PC.
- `o_rs1_data`  out  32  registered source operand 1.
- `o_rs2_data`  out  32  registered source operand 2.
- `o_imm`  out  32  registered sign-extended immediate.
- `o_rs1`  out  5  registered source index 1, for forwarding.
- `o_rs2`  out  5  registered source index 2, for forwarding.
- `o_branch`  out  1  registered: instruction is a BRANCH.
- `o_jal`  out  1  registered: instruction is JAL.
- `o_jalr`  out  1  registered: instruction is JALR.
- `o_illegal`  out  1  registered: unknown opcode.

## Operation
- **Immediate extraction by opcode, always sign-extended from bit 31:**
  - I-type: IMMEDIATE, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH; bit 0 = 0.
  - U-type: LUI, AUIPC; `{imm, 12'b0}`.
  - J-type: JAL; bit 0 = 0.
  - R_R: immediate = 0.
- **Control decode:**
  - R_R: `alu_src1`=0, `alu_src2`=0, `alu_op`=funct3, `arith_logic`=funct7[5], `rf_wr`=1.
  - IMMEDIATE: `alu_src2`=1, `alu_op`=funct3. `arith_logic`=funct7[5] only when funct3=F3_SRL_SRA, otherwise 0. `rf_wr`=1.
  - LOAD: `alu_src2`=1, `alu_op`=ADD, `dmem_rd`=1, `ld_st_funct3`=funct3, `rf_wr`=1, `wb_to_rf`=1 (memory).
  - STORE: `alu_src2`=1, `alu_op`=ADD, `dmem_wr`=1, `ld_st_funct3`=funct3, `rf_wr`=0.
  - BRANCH: `alu_src1`=0, `alu_src2`=0, `ld_st_funct3`=funct3 (comparison type), `rf_wr`=0, `o_branch`=1.
  - LUI: `alu_src2`=1, `alu_op`=ADD, `o_rs1_data` forced to 0, `rf_wr`=1.
  - AUIPC: `alu_src1`=1, `alu_src2`=1, `alu_op`=ADD, `rf_wr`=1.
  - JAL/JALR: `rf_wr`=1. JAL sets `alu_src1`=1; JALR sets `alu_src1`=0. Both set `alu_src2`=1. Link value (pc+4) is generated in EX.
- **`rd` field:**
  - `rd` = instruction rd for writing opcodes; `rd` = 0 when `rf_wr`=0.
  - `rf_wr` is cleared when rd = 0.
- **Illegal opcode:**
  - `o_illegal`=1 and `o_valid`=1.
  - All `o_ctrl` fields are 0, so the instruction has no architectural effect.
- **Register file:**
  - Two combinational read ports and one write port.
  - Write occurs when `i_wb_rf_wr` && `i_wb_rd`≠0.
  - Write-through bypass: a read of `i_wb_rd` in the same cycle returns `i_wb_data`.
  - Reads of x0 return 0.
- **Source usage:**
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by R_R, STORE and BRANCH.
- **Load-use hazard:**
  - `o_stall` = `i_valid` && !`i_flush` && `o_valid` && `o_ctrl.dmem_rd` && `o_ctrl.rd`≠0 && (`o_ctrl.rd` matches a *used* source index).

## Timing
- Decode-to-ID/EX latency is 1 cycle. `o_stall` is combinational in the same cycle.
- **Next-cycle ID/EX content, in priority order:**
  1. `i_reset`: all outputs 0 (asynchronously).
  2. `i_flush`: bubble.
  3. `o_stall`: bubble; fetch holds the instruction, so it re-decodes next cycle.
  4. `!i_valid`: bubble.
  5. Otherwise: the decoded instruction.
- A bubble means `o_valid`=0 and all other outputs are 0.
- **Reset:**
  - Clears every ID/EX field and all registers to 0.
  - If asserted mid-stall, the stall drops immediately, because `o_valid` becomes 0.
- **Simultaneous events:**
  - Flush and stall in the same cycle: flush wins and `o_stall`=0.
  - Writeback and read of the same register in the same cycle: bypass applies.
- At most one stall cycle per load-use pair. On the following cycle ID/EX holds a bubble, so `o_stall`=0.

## Structure
- **Add to `riscv_defs`:**
  - `id_ex_t` packed struct: valid, ctrl, pc, rs1_data, rs2_data, imm, rs1, rs2, branch, jal, jalr, illegal.
  - `imm_sel_t` enum: I, S, B, U, J, NONE.
- **Sub-module `riscv_regfile`:** 2R/1W register file with x0 hardwiring and write-through bypass; it is reused by the verification model.
- **Rest of the block:** a decode function, the hazard comparator, and the ID/EX register, all in the top level.

## Test plan
- **Decode ADDI** x5,x0,-3 (0xFFD00293): next cycle `o_imm`=0xFFFFFFFD, `alu_src2`=1, `alu_op`=000, `rd`=5, `rf_wr`=1, `o_valid`=1.
- **Load-use:** LW x6,0(x1) followed by ADD x7,x6,x2 → `o_stall`=1 for exactly one cycle, ID/EX bubble, then ADD issues with `o_rs1`=6. The same sequence with ADD x7,x2,x2 → no stall.
- **Writeback bypass:** `i_wb_rf_wr`=1, `i_wb_rd`=3, `i_wb_data`=0x1234, while decoding ADD x4,x3,x0 → `o_rs1_data`=0x1234. Writing x0 with 0xFF → a later read of x0 returns 0.
- **Flush priority:** `i_flush`=1 in the same cycle as a load-use stall condition → `o_stall`=0 and ID/EX is a bubble.
- **Immediates:** BEQ with offset −8 → `o_imm`=0xFFFFFFF8. JAL with offset +2048 → `o_imm`=0x00000800, `o_jal`=1. LUI 0xABCDE → `o_imm`=0xABCDE000 and `o_rs1_data`=0.
- **Illegal/reset:** opcode 0x7F → `o_illegal`=1 and `o_ctrl`=0. Asserting `i_reset` mid-stream → all outputs 0 immediately, and all registers read 0 afterwards.
